// File: rtl/unit_controller.sv
// ---------------------------------------------------------------------------
// unit_controller
//
// Multi-cycle control unit for a small load/store machine. It fetches a
// 16-bit instruction from a registered ROM, decodes it, and sequences the
// datapath through one or two execute cycles per instruction.
//
// Ports
//   clk           in   1   rising-edge system clock
//   reset         in   1   asynchronous active-high reset
//   instr         in  16   ROM word (valid one cycle after PC_Out changes)
//   PC_Out        out  7   instruction ROM address
//   IR_Out        out 16   instruction register
//   State_Out     out  4   current FSM state (debug)
//   D_Addr        out  8   data memory address
//   D_WriteEn     out  1   data memory write enable
//   MuxS          out  1   write-back select (1 = memory, 0 = ALU)
//   RegF_W_addr   out  4   register file write address
//   RegF_W_en     out  1   register file write enable
//   RegF_Ra_addr  out  4   register file read port A address
//   RegF_Rb_addr  out  4   register file read port B address
//   ALU_S         out  3   ALU select (0 pass, 1 add, 2 subtract)
// ---------------------------------------------------------------------------
module unit_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    output logic [6:0]  PC_Out,
    output logic [15:0] IR_Out,
    output logic [3:0]  State_Out,
    output logic [7:0]  D_Addr,
    output logic        D_WriteEn,
    output logic        MuxS,
    output logic [3:0]  RegF_W_addr,
    output logic        RegF_W_en,
    output logic [3:0]  RegF_Ra_addr,
    output logic [3:0]  RegF_Rb_addr,
    output logic [2:0]  ALU_S
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_t      state_reg;
    state_t      state_next;
    logic [6:0]  pc_reg;
    logic [15:0] ir_reg;

    // Instruction fields
    logic [3:0] opcode;
    logic [7:0] mem_addr;
    logic [3:0] fld_hi;   // Ra for ADD/SUB
    logic [3:0] fld_mid;  // Rb for ADD/SUB
    logic [3:0] fld_lo;   // Rd for LOAD/ADD/SUB, Ra for STORE

    assign opcode   = ir_reg[15:12];
    assign mem_addr = ir_reg[11:4];
    assign fld_hi   = ir_reg[11:8];
    assign fld_mid  = ir_reg[7:4];
    assign fld_lo   = ir_reg[3:0];

    // State, PC and IR registers. PC/IR only move on the edge leaving FETCH;
    // the ROM word is already valid there because PC has been stable since
    // the previous FETCH (or since reset for the very first fetch).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_INIT;
            pc_reg    <= 7'd0;
            ir_reg    <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH) begin
                ir_reg <= instr;
                pc_reg <= pc_reg + 7'd1;  // wraps 127 -> 0 naturally
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_next = S_NOOP;
                    OP_LOAD:  state_next = S_LOAD_A;
                    OP_STORE: state_next = S_STORE;
                    OP_ADD:   state_next = S_ADD;
                    OP_SUB:   state_next = S_SUB;
                    OP_HALT:  state_next = S_HALT;
                    default:  state_next = S_NOOP;  // undefined opcodes
                endcase
            end
            S_LOAD_A: state_next = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_INIT;
        endcase
    end

    // Moore outputs: decoded only from registered state and IR, so an async
    // reset clears them in the same cycle it is asserted.
    always_comb begin
        D_Addr       = 8'd0;
        D_WriteEn    = 1'b0;
        MuxS         = 1'b0;
        RegF_W_addr  = 4'd0;
        RegF_W_en    = 1'b0;
        RegF_Ra_addr = 4'd0;
        RegF_Rb_addr = 4'd0;
        ALU_S        = 3'd0;
        case (state_reg)
            S_LOAD_A: begin
                // Present the address a cycle early to cover the RAM read latency.
                D_Addr = mem_addr;
                MuxS   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr      = mem_addr;
                MuxS        = 1'b1;
                RegF_W_addr = fld_lo;
                RegF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr       = mem_addr;
                RegF_Ra_addr = fld_lo;
                D_WriteEn    = 1'b1;
            end
            S_ADD, S_SUB: begin
                RegF_Ra_addr = fld_hi;
                RegF_Rb_addr = fld_mid;
                RegF_W_addr  = fld_lo;
                RegF_W_en    = 1'b1;
                ALU_S        = (state_reg == S_ADD) ? 3'd1 : 3'd2;
            end
            default: ;
        endcase
    end

    assign PC_Out    = pc_reg;
    assign IR_Out    = ir_reg;
    assign State_Out = state_reg;

endmodule

// File: tb/tb_unit_controller.sv
// ---------------------------------------------------------------------------
// tb_unit_controller
//
// Drives unit_controller from a registered ROM model and checks every cycle
// against an instruction-level reference: each instruction expands into the
// list of cycles it should take and the control values each cycle must show.
// ---------------------------------------------------------------------------
module tb_unit_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr;
    logic [6:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  State_Out;
    logic [7:0]  D_Addr;
    logic        D_WriteEn;
    logic        MuxS;
    logic [3:0]  RegF_W_addr;
    logic        RegF_W_en;
    logic [3:0]  RegF_Ra_addr;
    logic [3:0]  RegF_Rb_addr;
    logic [2:0]  ALU_S;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [0:127];
    logic [6:0]  m_pc;
    logic [15:0] m_ir;

    unit_controller dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .PC_Out       (PC_Out),
        .IR_Out       (IR_Out),
        .State_Out    (State_Out),
        .D_Addr       (D_Addr),
        .D_WriteEn    (D_WriteEn),
        .MuxS         (MuxS),
        .RegF_W_addr  (RegF_W_addr),
        .RegF_W_en    (RegF_W_en),
        .RegF_Ra_addr (RegF_Ra_addr),
        .RegF_Rb_addr (RegF_Rb_addr),
        .ALU_S        (ALU_S)
    );

    always #5 clk = ~clk;

    // Registered instruction ROM
    always @(posedge clk) instr <= rom[PC_Out];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every DUT output against the expected values for this cycle.
    task automatic expect_cycle(input string tag, input logic [3:0] st,
                                input logic [7:0] da, input logic dwe,
                                input logic mux, input logic [3:0] wa,
                                input logic wen, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [2:0] alu);
        logic [52:0] got;
        logic [52:0] want;
        got  = {State_Out, PC_Out, IR_Out, D_Addr, D_WriteEn, MuxS,
                RegF_W_addr, RegF_W_en, RegF_Ra_addr, RegF_Rb_addr, ALU_S};
        want = {st, m_pc, m_ir, da, dwe, mux, wa, wen, ra, rb, alu};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got st=%0d pc=%0d ir=%h vec=%h want st=%0d pc=%0d ir=%h vec=%h",
                   tag, State_Out, PC_Out, IR_Out, got, st, m_pc, m_ir, want);
        end
        checks++;
        assert (!(D_WriteEn === 1'b1 && RegF_W_en === 1'b1)) else begin
            errors++;
            $error("FAIL %s_excl got dwe=%b wen=%b want not both 1", tag, D_WriteEn, RegF_W_en);
        end
    endtask

    task automatic expect_idle(input string tag, input logic [3:0] st);
        expect_cycle(tag, st, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
    endtask

    // Async reset: outputs must clear within the same cycle.
    task automatic assert_reset(input string tag);
        reset = 1'b1;
        #1;
        m_pc = 7'd0;
        m_ir = 16'd0;
        expect_idle(tag, 4'd0);
        repeat (2) tick();
        expect_idle({tag, "_hold"}, 4'd0);
    endtask

    // Release reset between edges; leaves the DUT in its first FETCH.
    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_idle("init", 4'd0);
        tick();
    endtask

    // Run one full instruction starting in FETCH. Returns 1 on HALT.
    task automatic exec_one(output bit halted);
        logic [3:0] op;
        halted = 1'b0;
        expect_idle("fetch", 4'd1);
        tick();
        m_ir = rom[m_pc];
        m_pc = m_pc + 7'd1;
        expect_idle("decode", 4'd2);
        tick();
        op = m_ir[15:12];
        $display("pc=%0d instr=%h op=%0d", m_pc - 7'd1, m_ir, op);
        case (op)
            4'd1: begin
                expect_cycle("load_a", 4'd4, m_ir[11:4], 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
                tick();
                expect_cycle("load_b", 4'd5, m_ir[11:4], 1'b0, 1'b1, m_ir[3:0], 1'b1, 4'd0, 4'd0, 3'd0);
                tick();
            end
            4'd2: begin
                expect_cycle("store", 4'd6, m_ir[11:4], 1'b1, 1'b0, 4'd0, 1'b0, m_ir[3:0], 4'd0, 3'd0);
                tick();
            end
            4'd3: begin
                expect_cycle("add", 4'd7, 8'd0, 1'b0, 1'b0, m_ir[3:0], 1'b1, m_ir[11:8], m_ir[7:4], 3'd1);
                tick();
            end
            4'd4: begin
                expect_cycle("sub", 4'd8, 8'd0, 1'b0, 1'b0, m_ir[3:0], 1'b1, m_ir[11:8], m_ir[7:4], 3'd2);
                tick();
            end
            4'd5: begin
                for (int i = 0; i < 6; i++) begin
                    expect_idle("halt", 4'd9);
                    tick();
                end
                halted = 1'b1;
            end
            default: begin
                expect_idle("noop", 4'd3);
                tick();
            end
        endcase
    endtask

    initial begin
        bit          h;
        logic [3:0]  op;
        logic [11:0] low;

        // Program: directed words first, then random non-HALT words, then HALT.
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h10B1;
        rom[1] = 16'h3560;
        rom[2] = 16'h4140;
        rom[3] = 16'h2CD0;
        rom[4] = 16'hF123;
        for (int i = 5; i < 45; i++) begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'd5);
            low = 12'($urandom);
            rom[i] = {op, low};
        end
        rom[45] = 16'h5000;

        #2;
        assert_reset("reset");
        release_reset();
        h = 1'b0;
        for (int n = 0; n < 46 && !h; n++) exec_one(h);
        checks++;
        assert (h === 1'b1) else begin
            errors++;
            $error("FAIL halt_reached got %b want 1", h);
        end

        // Reset in the middle of LOAD_A
        assert_reset("reset2");
        release_reset();
        expect_idle("fetch", 4'd1);
        tick();
        m_ir = rom[0];
        m_pc = 7'd1;
        expect_idle("decode", 4'd2);
        tick();
        expect_cycle("load_a", 4'd4, 8'd11, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
        #3;
        assert_reset("reset_mid_load");

        // All-NOOP program (including undefined opcodes) to wrap the PC.
        for (int i = 0; i < 128; i++) begin
            op = 4'($urandom_range(5, 15));
            if (op == 4'd5) op = 4'd0;
            low = 12'($urandom);
            rom[i] = {op, low};
        end
        release_reset();
        for (int n = 0; n < 128; n++) exec_one(h);
        checks++;
        assert (PC_Out === 7'd0 && State_Out === 4'd1) else begin
            errors++;
            $error("FAIL wrap got pc=%0d st=%0d want pc=0 st=1", PC_Out, State_Out);
        end
        for (int n = 0; n < 2; n++) exec_one(h);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
